sa_ar_channel: RTL



---
 rtl/sa_ar_channel.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/sa_ar_channel.sv
// sa_ar_channel: slave-side read-address stage.
// Round-robin arbitrates the dispatcher AR requests and prefixes the winning
// master index onto ARID. Every issued (sub-)burst is announced to the
// read-data RLAST filter FIFO.
// Optional feature macro: SA_AR_BURST_SPLIT_EN. When it is defined, INCR
// bursts that cross a 2^BOUNDARY_W byte page are issued as two sub-bursts,
// and the first part carries the crossing flag.
module sa_ar_channel #(
   parameter int MST_AMT         = 3,
   parameter int OUTSTANDING_AMT = 8,
   parameter int MST_ID_W        = $clog2(MST_AMT),
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int TRANS_MST_ID_W  = 5,
   parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
   parameter int BOUNDARY_W      = 10
) (
   input  logic                               ACLK_i,
   input  logic                               ARESETn_i,
   input  logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_ARID_i,
   input  logic [ADDR_WIDTH*MST_AMT-1:0]      dsp_ARADDR_i,
   input  logic [8*MST_AMT-1:0]               dsp_ARLEN_i,
   input  logic [3*MST_AMT-1:0]               dsp_ARSIZE_i,
   input  logic [2*MST_AMT-1:0]               dsp_ARBURST_i,
   input  logic [MST_AMT-1:0]                 dsp_ARVALID_i,
   output logic [MST_AMT-1:0]                 dsp_ARREADY_o,
   output logic [TRANS_SLV_ID_W-1:0]          s_ARID_o,
   output logic [ADDR_WIDTH-1:0]              s_ARADDR_o,
   output logic [7:0]                         s_ARLEN_o,
   output logic [2:0]                         s_ARSIZE_o,
   output logic [1:0]                         s_ARBURST_o,
   output logic                               s_ARVALID_o,
   input  logic                               s_ARREADY_i,
   output logic [TRANS_SLV_ID_W-1:0]          AR_AxID_o,
   output logic                               AR_crossing_flag_o,
   output logic                               AR_shift_en_o,
   input  logic                               AR_stall_i
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEND_1 = 2'd1;
   localparam logic [1:0] HOLD_2 = 2'd2;
   localparam logic [1:0] SEND_2 = 2'd3;

   localparam logic [1:0] BURST_INCR = 2'b01;

   // A page must hold the longest possible full-width burst, otherwise a
   // burst could cross more than once.
   generate
      if (((2 ** BOUNDARY_W) < (256 * DATA_WIDTH / 8)) || (OUTSTANDING_AMT < 1)) begin : g_cfg_err
         $error("sa_ar_channel: page smaller than a maximal burst or no outstanding slots");
      end
   endgenerate

   logic [1:0]                state_r;
   logic [MST_ID_W-1:0]       last_grant_r;
   logic [MST_ID_W-1:0]       grant_idx_s;
   logic                      grant_found_s;
   logic                      grant_en_s;
   int                        cand_s;

   logic [TRANS_MST_ID_W-1:0] sel_id_s;
   logic [ADDR_WIDTH-1:0]     sel_addr_s;
   logic [7:0]                sel_len_s;
   logic [2:0]                sel_size_s;
   logic [1:0]                sel_burst_s;

   logic                      split_s;
   logic [7:0]                first_len_s;
   logic [7:0]                second_len_s;
   logic [ADDR_WIDTH-1:0]     second_addr_s;

   logic [TRANS_SLV_ID_W-1:0] id_r;
   logic [ADDR_WIDTH-1:0]     addr_r;
   logic [7:0]                len_r;
   logic [2:0]                size_r;
   logic [1:0]                burst_r;
   logic                      valid_r;
   logic                      cross_r;
   logic [ADDR_WIDTH-1:0]     addr2_r;
   logic [7:0]                len2_r;

   // Round-robin search starting at the master after the last grant.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_s        = 0;
      for (int k = 1; k <= MST_AMT; k++) begin
         cand_s = (int'(last_grant_r) + k) % MST_AMT;
         if (!grant_found_s && dsp_ARVALID_i[cand_s[MST_ID_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s[MST_ID_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign grant_en_s = (state_r == IDLE) && grant_found_s && !AR_stall_i;

   // Master ready is combinational so the dispatcher handshakes in the grant cycle.
   always_comb begin
      dsp_ARREADY_o = '0;
      if (grant_en_s && ARESETn_i) begin
         dsp_ARREADY_o[grant_idx_s] = 1'b1;
      end else begin
         dsp_ARREADY_o = '0;
      end
   end

   // Select the winning master's AR payload.
   always_comb begin
      sel_id_s    = dsp_ARID_i[TRANS_MST_ID_W-1:0];
      sel_addr_s  = dsp_ARADDR_i[ADDR_WIDTH-1:0];
      sel_len_s   = dsp_ARLEN_i[7:0];
      sel_size_s  = dsp_ARSIZE_i[2:0];
      sel_burst_s = dsp_ARBURST_i[1:0];
      for (int i = 0; i < MST_AMT; i++) begin
         if (grant_idx_s == MST_ID_W'(i)) begin
            sel_id_s    = dsp_ARID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
            sel_addr_s  = dsp_ARADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len_s   = dsp_ARLEN_i[i*8 +: 8];
            sel_size_s  = dsp_ARSIZE_i[i*3 +: 3];
            sel_burst_s = dsp_ARBURST_i[i*2 +: 2];
         end else begin
            sel_id_s = sel_id_s;
         end
      end
   end

`ifdef SA_AR_BURST_SPLIT_EN
   logic [ADDR_WIDTH-1:0] aligned_s;
   logic [ADDR_WIDTH-1:0] bytes_s;
   logic [ADDR_WIDTH-1:0] end_s;
   logic [ADDR_WIDTH-1:0] page_next_s;
   logic [ADDR_WIDTH-1:0] beats1_s;

   // Page-crossing detection and the lengths of the two sub-bursts.
   always_comb begin
      aligned_s     = sel_addr_s & ({ADDR_WIDTH{1'b1}} << sel_size_s);
      bytes_s       = (ADDR_WIDTH'(sel_len_s) + ADDR_WIDTH'(1)) << sel_size_s;
      end_s         = aligned_s + bytes_s - ADDR_WIDTH'(1);
      page_next_s   = {aligned_s[ADDR_WIDTH-1:BOUNDARY_W] + (ADDR_WIDTH-BOUNDARY_W)'(1),
                       {BOUNDARY_W{1'b0}}};
      beats1_s      = (page_next_s - aligned_s) >> sel_size_s;
      second_addr_s = page_next_s;
      if ((sel_burst_s == BURST_INCR) &&
          (aligned_s[ADDR_WIDTH-1:BOUNDARY_W] != end_s[ADDR_WIDTH-1:BOUNDARY_W])) begin
         split_s     = 1'b1;
         first_len_s = beats1_s[7:0] - 8'd1;
      end else begin
         split_s     = 1'b0;
         first_len_s = sel_len_s;
      end
      second_len_s = sel_len_s - first_len_s - 8'd1;
   end

   assign AR_crossing_flag_o = cross_r;
`else
   assign split_s            = 1'b0;
   assign first_len_s        = sel_len_s;
   assign second_len_s       = 8'd0;
   assign second_addr_s      = '0;
   assign AR_crossing_flag_o = 1'b0;
`endif

   // Issue FSM and slave AR output registers; the register always empties
   // for a cycle after a handshake so the stall input sees each push.
   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         state_r      <= IDLE;
         last_grant_r <= MST_ID_W'(MST_AMT - 1);
         id_r         <= '0;
         addr_r       <= '0;
         len_r        <= 8'd0;
         size_r       <= 3'd0;
         burst_r      <= 2'd0;
         valid_r      <= 1'b0;
         cross_r      <= 1'b0;
         addr2_r      <= '0;
         len2_r       <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_en_s) begin
                  id_r         <= {grant_idx_s, sel_id_s};
                  addr_r       <= sel_addr_s;
                  len_r        <= first_len_s;
                  size_r       <= sel_size_s;
                  burst_r      <= sel_burst_s;
                  valid_r      <= 1'b1;
                  cross_r      <= split_s;
                  addr2_r      <= second_addr_s;
                  len2_r       <= second_len_s;
                  last_grant_r <= grant_idx_s;
                  state_r      <= SEND_1;
               end
            end
            SEND_1: begin
               if (s_ARREADY_i) begin
                  valid_r <= 1'b0;
                  cross_r <= 1'b0;
                  state_r <= cross_r ? HOLD_2 : IDLE;
               end
            end
            HOLD_2: begin
               if (!AR_stall_i) begin
                  addr_r  <= addr2_r;
                  len_r   <= len2_r;
                  valid_r <= 1'b1;
                  state_r <= SEND_2;
               end
            end
            SEND_2: begin
               if (s_ARREADY_i) begin
                  valid_r <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               valid_r <= 1'b0;
               cross_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign s_ARID_o      = id_r;
   assign s_ARADDR_o    = addr_r;
   assign s_ARLEN_o     = len_r;
   assign s_ARSIZE_o    = size_r;
   assign s_ARBURST_o   = burst_r;
   assign s_ARVALID_o   = valid_r;
   assign AR_AxID_o     = id_r;
   assign AR_shift_en_o = valid_r & s_ARREADY_i;

endmodule
